// File: rtl/ula_controle_8_if.sv
// ula_controle_8_if: request/result bundle of the ULA sequencer
// master drives operations and consumes results, slave is the controller
interface ula_controle_8_if #(parameter int N = 8);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] resultado;
    logic           flag_c;
    logic           flag_z;
    logic           Si;
    logic           Sma;
    logic           Sme;
    logic           busy;

    modport master (
        output in_valid, op, a1, b1, out_ready,
        input  in_ready, out_valid, resultado,
        input  flag_c, flag_z, Si, Sma, Sme, busy
    );

    modport slave (
        input  in_valid, op, a1, b1, out_ready,
        output in_ready, out_valid, resultado,
        output flag_c, flag_z, Si, Sma, Sme, busy
    );
endinterface

// File: rtl/ula_controle_8.sv
// ula_controle_8: one-at-a-time sequencer for the 8-bit ULA
// ADD/SUB/CMP finish in one CALC cycle, MUL runs N shift-add steps
module ula_controle_8 #(
    parameter int N = 8
) (
    input logic             clk,
    input logic             rst,
    ula_controle_8_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, MUL, DONE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     op_q;
    logic [2*N-1:0] a_sh;
    logic [N-1:0]   b_sh;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_nxt;
    logic [2*N-1:0] calc_res;
    logic           calc_c;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic           last;
    logic           fc, fz, fsi, fsma, fsme;

    // a_sh holds operand A in its low half until MUL starts shifting it
    assign sum     = {1'b0, a_sh[N-1:0]} + {1'b0, b_sh};
    assign diff    = {1'b0, a_sh[N-1:0]} - {1'b0, b_sh};
    assign acc_nxt = b_sh[0] ? acc + a_sh : acc;
    assign last    = (cnt == CW'(N - 1));

    always_comb begin
        calc_res = '0;
        calc_c   = 1'b0;
        case (op_q)
            2'b00: begin
                calc_res = {{(N-1){1'b0}}, sum};
                calc_c   = sum[N];
            end
            2'b01: begin
                calc_res = {{N{1'b0}}, diff[N-1:0]};
                calc_c   = diff[N];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid)
                      state_nxt = (bus.op == 2'b11) ? MUL : CALC;
            CALC: state_nxt = DONE;
            MUL:  if (last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            acc  <= '0;
            fc   <= 1'b0;
            fz   <= 1'b0;
            fsi  <= 1'b0;
            fsma <= 1'b0;
            fsme <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    op_q <= bus.op;
                    a_sh <= {{N{1'b0}}, bus.a1};
                    b_sh <= bus.b1;
                    cnt  <= '0;
                    acc  <= '0;
                end
                CALC: begin
                    acc  <= calc_res;
                    fc   <= calc_c;
                    fz   <= (calc_res == '0);
                    fsi  <= (op_q == 2'b10) && (a_sh[N-1:0] == b_sh);
                    fsma <= (op_q == 2'b10) && (a_sh[N-1:0] > b_sh);
                    fsme <= (op_q == 2'b10) && (a_sh[N-1:0] < b_sh);
                end
                MUL: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        fc   <= |acc_nxt[2*N-1:N];
                        fz   <= (acc_nxt == '0);
                        fsi  <= 1'b0;
                        fsma <= 1'b0;
                        fsme <= 1'b0;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.resultado = acc;
    assign bus.flag_c    = fc;
    assign bus.flag_z    = fz;
    assign bus.Si        = fsi;
    assign bus.Sma       = fsma;
    assign bus.Sme       = fsme;
endmodule

// File: tb/tb_ula_controle_8.sv
// tb_ula_controle_8: scoreboard bench for the ULA sequencer
// driver pushes expected results, monitor pops them on out_valid
module tb_ula_controle_8;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ula_controle_8_if #(.N(N)) bus ();

    ula_controle_8 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     op;
        logic [7:0]     a;
        logic [7:0]     b;
        logic [2*N+4:0] want;
        int             lat;
        int             t0;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   hold_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // reference: plain integer arithmetic on the operation rules
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input int t0);
        exp_t e;
        int unsigned ua, ub, r;
        logic c, si, sma, sme;
        ua = a; ub = b;
        c = 0; si = 0; sma = 0; sme = 0; r = 0;
        case (op)
            2'b00: begin r = ua + ub; c = (r > 255); end
            2'b01: begin r = (ua + 256 - ub) % 256; c = (ua < ub); end
            2'b10: begin si = (ua == ub); sma = (ua > ub); sme = (ua < ub); end
            default: begin r = ua * ub; c = (r > 255); end
        endcase
        e.op   = op;
        e.a    = a;
        e.b    = b;
        e.want = {r[2*N-1:0], c, (r == 0), si, sma, sme};
        e.lat  = (op == 2'b11) ? N + 1 : 2;
        e.t0   = t0;
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op       = 2'($urandom);
            bus.a1       = 8'($urandom);
            bus.b1       = 8'($urandom);
            w++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=0, want 1");
            bus.in_valid = 1'b0;
            return;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a1       = a;
        bus.b1       = b;
        q.push_back(model(op, a, b, cyc));
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1)) & ~bus.in_ready;
            w++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d, want 0", q.size());
            q.delete();
        end
    endtask

    // monitor: compares on out_valid, randomizes or holds out_ready
    initial begin
        logic [2*N+4:0] got, held;
        bit seen;
        exp_t e;
        seen = 0;
        held = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                got = {bus.resultado, bus.flag_c, bus.flag_z,
                       bus.Si, bus.Sma, bus.Sme};
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: out_valid=1, want 0");
                    bus.out_ready = 1'b1;
                end else begin
                    e = q[0];
                    if (!seen) begin
                        chk($sformatf("latency op%0d", e.op), 64'(cyc - e.t0),
                            64'(e.lat));
                        chk($sformatf("result op%0d %h,%h", e.op, e.a, e.b),
                            64'(got), 64'(e.want));
                        held = got;
                        seen = 1;
                    end else begin
                        chk("hold_stable", 64'(got), 64'(held));
                    end
                    if (hold_req > 0) begin
                        hold_req--;
                        chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
                        chk("hold_busy", 64'(bus.busy), 64'd1);
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'($urandom_range(0, 1));
                    end
                    if (bus.out_ready) begin
                        q.delete(0);
                        seen = 0;
                    end
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.a1       = '0;
        bus.b1       = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_resultado", 64'(bus.resultado), 64'd0);
        chk("rst_flags", 64'({bus.flag_c, bus.flag_z, bus.Si, bus.Sma, bus.Sme}),
            64'd0);
        rst = 1'b0;

        issue(2'b00, 8'hFF, 8'h01);
        issue(2'b01, 8'h10, 8'h20);
        issue(2'b01, 8'h55, 8'h55);
        issue(2'b10, 8'h80, 8'h7F);
        issue(2'b10, 8'h3C, 8'h3C);
        issue(2'b10, 8'h00, 8'h01);
        issue(2'b11, 8'hFF, 8'hFF);
        issue(2'b11, 8'h00, 8'hAB);
        drain();

        hold_req = 5;
        issue(2'b11, 8'h0C, 8'h0D);
        drain();

        // abort a multiply part way through its iterations
        issue(2'b11, 8'($urandom), 8'($urandom));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete(q.size() - 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_resultado", 64'(bus.resultado), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);

        issue(2'b00, 8'h02, 8'h03);
        drain();

        for (int i = 0; i < 60; i++)
            issue(2'($urandom), 8'($urandom), 8'($urandom));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
